fsm_req_sequencer: RTL and testbench

//  Upstream request stage for the 4-way grant FSM. Converts one-cycle client

---
 rtl/fsm_req_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_fsm_req_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_req_sequencer.sv
// fsm_req_sequencer: four independent request channels feeding the 4-way
// grant FSM. Each start pulse becomes a level request held for exactly LEN
// granted cycles. Optional grant-wait timeout is enabled by the macro
// REQ_TIMEOUT_EN (wait limit TIMEOUT_CYC cycles).

// Per-channel request FSM: IDLE -> WAIT -> HOLD -> RELEASE -> IDLE
module fsm_req_lane #(
  parameter int LEN_W = 4
`ifdef REQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             gnt,
  output logic             req,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_REL  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             done_evt, err_evt;

`ifdef REQ_TIMEOUT_EN
  localparam int WCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYC - 1);
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
`endif

  // State, counters and registered outputs; reset drops everything silently
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef REQ_TIMEOUT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef REQ_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  // Next-state and burst counter; cnt saturates at 1, never wraps
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_evt = 1'b0;
    err_evt  = 1'b0;
`ifdef REQ_TIMEOUT_EN
    wcnt_d   = '0;
`endif
    case (state_q)
      S_IDLE: begin
        // done_q/err_q high means this is the completion cycle: no restart yet
        if (start && !done_q && !err_q) begin
          state_d = S_WAIT;
          cnt_d   = (len == '0) ? CNT_ONE : len;
        end
      end
      S_WAIT: begin
        if (gnt) begin
          if (cnt_q == CNT_ONE) begin
            state_d = S_REL;
          end else begin
            cnt_d   = cnt_q - CNT_ONE;
            state_d = S_HOLD;
          end
        end
`ifdef REQ_TIMEOUT_EN
        else if (wcnt_q == WCNT_LAST) begin
          state_d = S_IDLE;
          err_evt = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
      end
      S_HOLD: begin
        if (gnt) begin
          if (cnt_q == CNT_ONE) state_d = S_REL;
          else                  cnt_d   = cnt_q - CNT_ONE;
        end else begin
          // arbiter pulled the grant before LEN cycles: abort
          state_d = S_IDLE;
          err_evt = 1'b1;
        end
      end
      S_REL: begin
        if (!gnt) begin
          state_d  = S_IDLE;
          done_evt = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from next state so every output comes straight off a flop
  always_comb begin
    req_d  = (state_d == S_WAIT) || (state_d == S_HOLD);
    busy_d = (state_d != S_IDLE);
    done_d = done_evt;
    err_d  = err_evt;
  end

  assign req  = req_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// Top: scalar client ports fanned into packed per-channel vectors
module fsm_req_sequencer #(
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_0,
  input  logic             start_1,
  input  logic             start_2,
  input  logic             start_3,
  input  logic [LEN_W-1:0] len_0,
  input  logic [LEN_W-1:0] len_1,
  input  logic [LEN_W-1:0] len_2,
  input  logic [LEN_W-1:0] len_3,
  input  logic             gnt_0,
  input  logic             gnt_1,
  input  logic             gnt_2,
  input  logic             gnt_3,
  output logic             req_0,
  output logic             req_1,
  output logic             req_2,
  output logic             req_3,
  output logic             busy_0,
  output logic             busy_1,
  output logic             busy_2,
  output logic             busy_3,
  output logic             done_0,
  output logic             done_1,
  output logic             done_2,
  output logic             done_3,
  output logic             err_0,
  output logic             err_1,
  output logic             err_2,
  output logic             err_3
);

  localparam int NUM_CH = 4;

  logic [NUM_CH-1:0]            start_v, gnt_v, req_v, busy_v, done_v, err_v;
  logic [NUM_CH-1:0][LEN_W-1:0] len_v;

  assign start_v = {start_3, start_2, start_1, start_0};
  assign gnt_v   = {gnt_3, gnt_2, gnt_1, gnt_0};
  assign len_v   = {len_3, len_2, len_1, len_0};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    fsm_req_lane #(
      .LEN_W(LEN_W)
`ifdef REQ_TIMEOUT_EN
      , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) u_lane (
      .clock (clock),
      .reset (reset),
      .start (start_v[i]),
      .len   (len_v[i]),
      .gnt   (gnt_v[i]),
      .req   (req_v[i]),
      .busy  (busy_v[i]),
      .done  (done_v[i]),
      .err   (err_v[i])
    );
  end

  assign {req_3,  req_2,  req_1,  req_0}  = req_v;
  assign {busy_3, busy_2, busy_1, busy_0} = busy_v;
  assign {done_3, done_2, done_1, done_0} = done_v;
  assign {err_3,  err_2,  err_1,  err_0}  = err_v;

endmodule

// File: tb/tb_fsm_req_sequencer.sv
// Directed bench for fsm_req_sequencer: completion/abort pulses are checked
// against a scoreboard queue, levels against inline expectations.
module tb_fsm_req_sequencer;

  localparam int LEN_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [3:0]       st = '0;
  logic [3:0]       gn = '0;
  logic [LEN_W-1:0] ln [4];
  logic [3:0]       req, busy, done, err;

  typedef struct {
    int ch;
    bit is_err;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clock = ~clock;

  fsm_req_sequencer #(.LEN_W(LEN_W), .TIMEOUT_CYC(16)) dut (
    .clock  (clock),
    .reset  (reset),
    .start_0(st[0]), .start_1(st[1]), .start_2(st[2]), .start_3(st[3]),
    .len_0  (ln[0]), .len_1  (ln[1]), .len_2  (ln[2]), .len_3  (ln[3]),
    .gnt_0  (gn[0]), .gnt_1  (gn[1]), .gnt_2  (gn[2]), .gnt_3  (gn[3]),
    .req_0  (req[0]), .req_1 (req[1]), .req_2 (req[2]), .req_3 (req[3]),
    .busy_0 (busy[0]), .busy_1(busy[1]), .busy_2(busy[2]), .busy_3(busy[3]),
    .done_0 (done[0]), .done_1(done[1]), .done_2(done[2]), .done_3(done[3]),
    .err_0  (err[0]), .err_1 (err[1]), .err_2 (err[2]), .err_3 (err[3])
  );

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, score any pulses
  task automatic tick();
    ev_t e;
    @(posedge clock);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (done[c] || err[c]) begin
        chk("evt_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("evt_ch", c, e.ch);
          chk("evt_is_err", int'(err[c]), int'(e.is_err));
          chk("evt_not_both", int'(done[c] && err[c]), 0);
        end
      end
    end
  endtask

  task automatic push_ev(input int ch, input bit is_err);
    ev_t e;
    e.ch = ch;
    e.is_err = is_err;
    exp_q.push_back(e);
  endtask

  task automatic drained(input string tag);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int c = 0; c < 4; c++) ln[c] = '0;

    // reset state
    tick(); tick();
    chk("rst_req",  req,  0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err",  err,  0);
    reset = 1'b1;
    tick();

    // 1: ch0 len=3, grant two cycles after req rises
    st[0] = 1'b1; ln[0] = 4'd3;
    tick();
    st[0] = 1'b0; ln[0] = 4'd9;
    chk("t1_req_rise",  req[0],  1);
    chk("t1_busy_rise", busy[0], 1);
    tick();
    chk("t1_req_wait", req[0], 1);
    gn[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t1_req_granted", req[0], 1);
      tick();
    end
    chk("t1_req_drop", req[0], 0);
    chk("t1_busy_rel", busy[0], 1);
    tick();
    chk("t1_rel_hold_gnt", busy[0], 1);
    drained("t1_no_early_done");
    push_ev(0, 1'b0);
    gn[0] = 1'b0;
    tick();
    drained("t1_done_seen");
    chk("t1_busy_fall", busy[0], 0);
    // start on the done cycle is ignored
    st[0] = 1'b1; ln[0] = 4'd2;
    tick();
    st[0] = 1'b0;
    chk("t1_start_on_done", busy[0], 0);
    tick();

    // 2: ch1 len=0 acts as len=1
    st[1] = 1'b1; ln[1] = 4'd0;
    tick();
    st[1] = 1'b0;
    chk("t2_req_rise", req[1], 1);
    gn[1] = 1'b1;
    tick();
    chk("t2_req_drop", req[1], 0);
    tick();
    chk("t2_busy_gnt_high", busy[1], 1);
    push_ev(1, 1'b0);
    gn[1] = 1'b0;
    tick();
    drained("t2_done_seen");
    chk("t2_busy_fall", busy[1], 0);
    tick();

    // 3: all four start together, len=2, grants serialized 0..3
    st = 4'hF;
    for (int c = 0; c < 4; c++) ln[c] = 4'd2;
    tick();
    st = 4'h0;
    chk("t3_req_all", req, 15);
    for (int c = 0; c < 4; c++) begin
      gn[c] = 1'b1;
      tick();
      chk("t3_req_hold", req[c], 1);
      tick();
      chk("t3_req_drop", req, (4'hE << c) & 4'hF);
      push_ev(c, 1'b0);
      gn[c] = 1'b0;
      tick();
      drained("t3_done_seen");
      chk("t3_busy", busy, (4'hE << c) & 4'hF);
    end
    tick();

    // 4: ch2 restart in HOLD ignored, then early grant drop
    st[2] = 1'b1; ln[2] = 4'd4;
    tick();
    st[2] = 1'b0;
    gn[2] = 1'b1;
    tick();
    st[2] = 1'b1; ln[2] = 4'd1;
    tick();
    st[2] = 1'b0;
    chk("t4_req_hold", req[2], 1);
    tick();
    chk("t4_no_resample", req[2], 1);
    push_ev(2, 1'b1);
    gn[2] = 1'b0;
    tick();
    drained("t4_err_seen");
    chk("t4_req_off",  req[2],  0);
    chk("t4_busy_off", busy[2], 0);
    // start on the err cycle is ignored
    st[2] = 1'b1; ln[2] = 4'd2;
    tick();
    st[2] = 1'b0;
    chk("t4_start_on_err", busy[2], 0);
    // grant in IDLE does nothing
    gn[2] = 1'b1;
    tick(); tick();
    chk("t4_idle_gnt_req",  req[2],  0);
    chk("t4_idle_gnt_busy", busy[2], 0);
    gn[2] = 1'b0;
    tick();

    // 5: reset mid-HOLD on ch3, then a clean burst
    st[3] = 1'b1; ln[3] = 4'd5;
    tick();
    st[3] = 1'b0;
    gn[3] = 1'b1;
    tick(); tick();
    chk("t5_req_hold", req[3], 1);
    reset = 1'b0;
    tick();
    chk("t5_rst_req",  req[3],  0);
    chk("t5_rst_busy", busy[3], 0);
    chk("t5_rst_done", done[3], 0);
    chk("t5_rst_err",  err[3],  0);
    reset = 1'b1;
    gn[3] = 1'b0;
    tick();
    st[3] = 1'b1; ln[3] = 4'd1;
    tick();
    st[3] = 1'b0;
    chk("t5_req_again", req[3], 1);
    gn[3] = 1'b1;
    tick();
    chk("t5_req_drop", req[3], 0);
    push_ev(3, 1'b0);
    gn[3] = 1'b0;
    tick();
    drained("t5_done_seen");
    chk("t5_busy_fall", busy[3], 0);
    tick();

    // 6: ch0 waits for a grant that never comes
    st[0] = 1'b1; ln[0] = 4'd2;
    tick();
    st[0] = 1'b0;
`ifdef REQ_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      chk("t6_req_waiting", req[0], 1);
      tick();
    end
    chk("t6_req_last_wait", req[0], 1);
    push_ev(0, 1'b1);
    tick();
    drained("t6_timeout_err");
    chk("t6_req_off",  req[0],  0);
    chk("t6_busy_off", busy[0], 0);
`else
    for (int k = 0; k < 120; k++) begin
      chk("t6_req_no_timeout", req[0], 1);
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("t6_busy_cleared", busy[0], 0);
`endif
    tick(); tick();
    drained("final_queue_empty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
